// File: rtl/dist_ram_pkg.sv
// -----------------------------------------------------------------------------
// dist_ram_pkg
// Shared definitions for the dual-port distributed RAM:
//   - default data width / depth constants
//   - clear-sequencer state encoding
//   - byte parity helper (used only when DIST_RAM_PARITY_EN is defined)
// -----------------------------------------------------------------------------
package dist_ram_pkg;

   localparam int DW_DEFAULT    = 32;
   localparam int DEPTH_DEFAULT = 64;

   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } state_e;

   // Even parity: the stored bit makes the 9-bit {byte, bit} group even.
   function automatic logic byte_par(input logic [7:0] b);
      return ^b;
   endfunction

endpackage

// File: rtl/dist_ram_byte_merge.sv
// -----------------------------------------------------------------------------
// dist_ram_byte_merge
// Combinational byte-lane merge: lanes with be set come from new_word, the
// rest keep old_word. Used both for the memory write data and for write-first
// forwarding to the read port.
//
// Ports:
//   old_word  in  DW     current contents of the addressed word
//   new_word  in  DW     incoming write data
//   be        in  DW/8   byte-lane enables
//   merged    out DW     resulting word
// -----------------------------------------------------------------------------
module dist_ram_byte_merge #(
   parameter int DW = 32
) (
   input  logic [DW-1:0]   old_word,
   input  logic [DW-1:0]   new_word,
   input  logic [DW/8-1:0] be,
   output logic [DW-1:0]   merged
);

   localparam int NB = DW / 8;

   always_comb begin
      merged = old_word;
      for (int i = 0; i < NB; i++) begin
         if (be[i]) merged[8*i +: 8] = new_word[8*i +: 8];
      end
   end

endmodule

// File: rtl/dist_ram_dp.sv
// -----------------------------------------------------------------------------
// dist_ram_dp
// Dual-port distributed RAM: one byte-enabled write port, one read port with a
// registered output (clock enable + synchronous clear). After reset a clear
// sequencer walks every address writing zero; user writes are ignored while it
// runs (init_busy=1). Same-address read/write in one cycle is write-first.
//
// Optional build macro DIST_RAM_PARITY_EN: stores one even-parity bit per byte
// lane and adds the registered par_err output.
//
// Ports:
//   clk        in   1     clock, all state changes on rising edge
//   rst_n      in   1     asynchronous active-low reset
//   a          in   AW    write address
//   d          in   DW    write data
//   we         in   1     write enable
//   be         in   NB    byte-lane write enables
//   dpra       in   AW    read address
//   qdpo_ce    in   1     output register clock enable
//   qdpo_srst  in   1     output register synchronous clear (beats qdpo_ce)
//   qdpo       out  DW    registered read data
//   par_err    out  1     registered parity mismatch (DIST_RAM_PARITY_EN only)
//   init_busy  out  1     high while the clear sequencer runs
// -----------------------------------------------------------------------------
module dist_ram_dp
   import dist_ram_pkg::*;
#(
   parameter  int DW    = DW_DEFAULT,
   parameter  int DEPTH = DEPTH_DEFAULT,
   localparam int AW    = $clog2(DEPTH),
   localparam int NB    = DW / 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [AW-1:0] a,
   input  logic [DW-1:0] d,
   input  logic          we,
   input  logic [NB-1:0] be,
   input  logic [AW-1:0] dpra,
   input  logic          qdpo_ce,
   input  logic          qdpo_srst,
   output logic [DW-1:0] qdpo,
`ifdef DIST_RAM_PARITY_EN
   output logic          par_err,
`endif
   output logic          init_busy
);

   state_e        state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] qdpo_q, qdpo_d;

   logic [DW-1:0] mem [DEPTH];

   logic          user_wr;
   logic          fwd;
   logic [DW-1:0] merged;
   logic          wr_en;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic [DW-1:0] rd_word;

   // ---------------------------------------------------------------------------
   // Clear sequencer
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no
      // path leaves it unassigned and infers a latch.
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == ST_INIT) begin
         // cnt is exactly AW bits wide, so it wraps back to 0 after DEPTH-1.
         cnt_d = cnt_q + AW'(1);
         if (cnt_q == AW'(DEPTH - 1)) state_d = ST_READY;
      end
   end

   assign init_busy = (state_q == ST_INIT);

   // ---------------------------------------------------------------------------
   // Write path
   // ---------------------------------------------------------------------------
   assign user_wr = we & ~init_busy;

   dist_ram_byte_merge #(.DW(DW)) u_merge (
      .old_word (mem[a]),
      .new_word (d),
      .be       (be),
      .merged   (merged)
   );

   always_comb begin
      wr_en   = user_wr;
      wr_addr = a;
      wr_data = merged;
      if (init_busy) begin
         wr_en   = 1'b1;
         wr_addr = cnt_q;
         wr_data = '0;
      end
   end

   // NOTE: the storage array has no reset; the clear sequencer zeroes it, which
   // keeps it mappable to LUT RAM.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end

   // ---------------------------------------------------------------------------
   // Read path (write-first on a same-address user write; no forwarding of the
   // clear writes, so reads during INIT see the word as currently stored)
   // ---------------------------------------------------------------------------
   assign fwd     = user_wr && (a == dpra);
   assign rd_word = fwd ? merged : mem[dpra];

   always_comb begin
      qdpo_d = qdpo_q;
      if (qdpo_srst)    qdpo_d = '0;
      else if (qdpo_ce) qdpo_d = rd_word;
   end

   assign qdpo = qdpo_q;

`ifdef DIST_RAM_PARITY_EN
   // ---------------------------------------------------------------------------
   // Per-lane even parity
   // ---------------------------------------------------------------------------
   logic [NB-1:0] par_mem [DEPTH];
   logic [NB-1:0] wr_par_user;
   logic [NB-1:0] wr_par;
   logic [NB-1:0] rd_par;
   logic          lane_err;
   logic          par_err_q, par_err_d;

   // Disabled lanes keep their stored parity so an existing corruption in
   // those lanes is still caught on a later read.
   always_comb begin
      wr_par_user = par_mem[a];
      for (int i = 0; i < NB; i++) begin
         if (be[i]) wr_par_user[i] = byte_par(d[8*i +: 8]);
      end
   end

   assign wr_par = init_busy ? '0 : wr_par_user;

   always_ff @(posedge clk) begin
      if (wr_en) par_mem[wr_addr] <= wr_par;
   end

   assign rd_par = fwd ? wr_par_user : par_mem[dpra];

   always_comb begin
      lane_err = 1'b0;
      for (int i = 0; i < NB; i++) begin
         if (byte_par(rd_word[8*i +: 8]) != rd_par[i]) lane_err = 1'b1;
      end
   end

   always_comb begin
      par_err_d = par_err_q;
      if (qdpo_srst)    par_err_d = 1'b0;
      else if (qdpo_ce) par_err_d = lane_err;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) par_err_q <= 1'b0;
      else        par_err_q <= par_err_d;
   end

   assign par_err = par_err_q;
`endif

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // values from before the edge, independent of block ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
         qdpo_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         qdpo_q  <= qdpo_d;
      end
   end

endmodule

// File: tb/tb_dist_ram_dp.sv
// -----------------------------------------------------------------------------
// tb_dist_ram_dp
// Self-checking bench for dist_ram_dp (DW=32, DEPTH=64). Inputs change and
// outputs are sampled 1 ns after each rising edge. A word-level array model
// supplies expected read data for the randomized phase.
// -----------------------------------------------------------------------------
module tb_dist_ram_dp;

   localparam int DW    = 32;
   localparam int DEPTH = 64;
   localparam int AW    = 6;
   localparam int NB    = 4;

   logic          clk;
   logic          rst_n;
   logic [AW-1:0] a;
   logic [DW-1:0] d;
   logic          we;
   logic [NB-1:0] be;
   logic [AW-1:0] dpra;
   logic          qdpo_ce;
   logic          qdpo_srst;
   logic [DW-1:0] qdpo;
   logic          init_busy;
`ifdef DIST_RAM_PARITY_EN
   logic          par_err;
`endif

   dist_ram_dp #(.DW(DW), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .a         (a),
      .d         (d),
      .we        (we),
      .be        (be),
      .dpra      (dpra),
      .qdpo_ce   (qdpo_ce),
      .qdpo_srst (qdpo_srst),
      .qdpo      (qdpo),
`ifdef DIST_RAM_PARITY_EN
      .par_err   (par_err),
`endif
      .init_busy (init_busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_vec  = 0;
   int n_miss = 0;

   logic [DW-1:0] exp_mem [DEPTH];
   logic [DW-1:0] exp_q;

   typedef struct {
      logic          we;
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      logic [NB-1:0] be;
      logic [AW-1:0] dpra;
      logic          ce;
      logic          srst;
      logic [DW-1:0] exp_q;
   } vec_t;

   vec_t vecs [15];

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference behaviour of one clock edge: apply the byte-masked write, then
   // the output register sees the updated array (write-first).
   task automatic model_edge(input logic w, input logic [AW-1:0] aa, input logic [DW-1:0] dd,
                             input logic [NB-1:0] bb, input logic [AW-1:0] ra,
                             input logic c, input logic s);
      if (w) begin
         for (int i = 0; i < NB; i++) begin
            if (bb[i]) exp_mem[aa][8*i +: 8] = dd[8*i +: 8];
         end
      end
      if (s)      exp_q = '0;
      else if (c) exp_q = exp_mem[ra];
   endtask

   task automatic apply(input logic w, input logic [AW-1:0] aa, input logic [DW-1:0] dd,
                        input logic [NB-1:0] bb, input logic [AW-1:0] ra,
                        input logic c, input logic s);
      we = w; a = aa; d = dd; be = bb; dpra = ra; qdpo_ce = c; qdpo_srst = s;
      step();
      model_edge(w, aa, dd, bb, ra, c, s);
   endtask

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
      exp_q = '0;
   endtask

   // Counts edges until init_busy drops (bounded) and checks it took DEPTH.
   task automatic count_init(input string name);
      int n;
      n = 0;
      while (init_busy && n < 4 * DEPTH) begin
         step();
         n++;
      end
      check(name, DW'(n), DW'(DEPTH));
   endtask

   task automatic read_all_zero(input string name);
      for (int i = 0; i < DEPTH; i++) begin
         apply(1'b0, '0, '0, '0, AW'(i), 1'b1, 1'b0);
         check($sformatf("%s[%0d]", name, i), qdpo, '0);
      end
   endtask

   initial begin
      vecs[0]  = '{1'b1, 6'd5,  32'hA5A5_1234, 4'hF,    6'd0,  1'b0, 1'b0, 32'h0000_0000};
      vecs[1]  = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd5,  1'b1, 1'b0, 32'hA5A5_1234};
      vecs[2]  = '{1'b1, 6'd5,  32'h0000_00FF, 4'b0001, 6'd5,  1'b1, 1'b0, 32'hA5A5_12FF};
      vecs[3]  = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd5,  1'b1, 1'b1, 32'h0000_0000};
      vecs[4]  = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd6,  1'b0, 1'b0, 32'h0000_0000};
      vecs[5]  = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd5,  1'b1, 1'b0, 32'hA5A5_12FF};
      vecs[6]  = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd9,  1'b0, 1'b0, 32'hA5A5_12FF};
      vecs[7]  = '{1'b1, 6'd9,  32'hDEAD_BEEF, 4'b1010, 6'd5,  1'b1, 1'b0, 32'hA5A5_12FF};
      vecs[8]  = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd9,  1'b1, 1'b0, 32'hDE00_BE00};
      vecs[9]  = '{1'b1, 6'd9,  32'h1122_3344, 4'h0,    6'd9,  1'b1, 1'b0, 32'hDE00_BE00};
      vecs[10] = '{1'b1, 6'd63, 32'hCAFE_F00D, 4'b1100, 6'd63, 1'b1, 1'b0, 32'hCAFE_0000};
      vecs[11] = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd0,  1'b1, 1'b0, 32'h0000_0000};
      vecs[12] = '{1'b1, 6'd0,  32'h1234_5678, 4'hF,    6'd63, 1'b1, 1'b0, 32'hCAFE_0000};
      vecs[13] = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd0,  1'b1, 1'b0, 32'h1234_5678};
      vecs[14] = '{1'b0, 6'd0,  32'h0,         4'h0,    6'd0,  1'b0, 1'b1, 32'h0000_0000};

      // ---- reset state; a user write to address 3 is held during INIT ----
      rst_n = 1'b0;
      we = 1'b1; a = 6'd3; d = 32'h1; be = 4'hF;
      dpra = '0; qdpo_ce = 1'b0; qdpo_srst = 1'b0;
      #12;
      check("rst_qdpo", qdpo, '0);
      check("rst_init_busy", DW'(init_busy), DW'(1));
      step();
      rst_n = 1'b1;
      count_init("init_cycles");
      we = 1'b0;
      model_clear();
      read_all_zero("clear_rd");

      // ---- directed table ----
      for (int i = 0; i < 15; i++) begin
         apply(vecs[i].we, vecs[i].a, vecs[i].d, vecs[i].be, vecs[i].dpra, vecs[i].ce, vecs[i].srst);
         check($sformatf("vec%0d", i), qdpo, vecs[i].exp_q);
      end

      // ---- randomized against the array model ----
      for (int i = 0; i < 400; i++) begin
         logic          w, c, s;
         logic [AW-1:0] aa, ra;
         logic [DW-1:0] dd;
         logic [NB-1:0] bb;
         w  = 1'($urandom_range(0, 1));
         aa = AW'($urandom);
         dd = $urandom;
         bb = NB'($urandom);
         ra = ($urandom_range(0, 3) == 0) ? aa : AW'($urandom);
         c  = ($urandom_range(0, 3) != 0);
         s  = ($urandom_range(0, 15) == 0);
         apply(w, aa, dd, bb, ra, c, s);
         check($sformatf("rand%0d", i), qdpo, exp_q);
`ifdef DIST_RAM_PARITY_EN
         check($sformatf("rand_par%0d", i), DW'(par_err), '0);
`endif
      end

      // ---- reset pulse in the middle of INIT restarts the full clear ----
      we = 1'b0; qdpo_ce = 1'b0; qdpo_srst = 1'b0;
      rst_n = 1'b0;
      #2;
      check("rst2_qdpo", qdpo, '0);
      check("rst2_init_busy", DW'(init_busy), DW'(1));
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) step();
      rst_n = 1'b0;
      #2;
      check("mid_rst_init_busy", DW'(init_busy), DW'(1));
      #1;
      rst_n = 1'b1;
      count_init("restart_cycles");
      model_clear();
      read_all_zero("restart_rd");

`ifdef DIST_RAM_PARITY_EN
      // ---- parity: corrupt a stored bit in lane 2 of word 7 ----
      apply(1'b1, 6'd7, 32'h1122_3344, 4'hF, 6'd7, 1'b1, 1'b0);
      check("par_clean", DW'(par_err), '0);
      dut.mem[7][18] = ~dut.mem[7][18];
      apply(1'b0, '0, '0, '0, 6'd7, 1'b1, 1'b0);
      check("par_detect", DW'(par_err), DW'(1));
      apply(1'b0, '0, '0, '0, 6'd7, 1'b0, 1'b0);
      check("par_hold", DW'(par_err), DW'(1));
      apply(1'b0, '0, '0, '0, 6'd7, 1'b1, 1'b1);
      check("par_srst", DW'(par_err), '0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/dist_ram_dp.md
DIST_RAM_DP -- requirements
Module: dist_ram_dp

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits, multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 64, number of words, power of two, at least 2.
REQ-003 SHALL have localparam AW = clog2(DEPTH), address width, and NB = DW/8, byte-lane count.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port a, input, AW, write address.
REQ-007 SHALL have port d, input, DW, write data.
REQ-008 SHALL have port we, input, 1, write enable.
REQ-009 SHALL have port be, input, NB, byte-lane write enables; be[i] gates d[8i+7:8i].
REQ-010 SHALL have port dpra, input, AW, read address.
REQ-011 SHALL have port qdpo_ce, input, 1, output register clock enable.
REQ-012 SHALL have port qdpo_srst, input, 1, synchronous output register clear.
REQ-013 SHALL have port qdpo, output, DW, registered read data.
REQ-014 SHALL have port init_busy, output, 1, high while the clear sequencer runs.

Function
REQ-015 SHALL write d lanes with be set to mem[a] at the clock edge when we=1 and init_busy=0; lanes with be clear are unchanged.
REQ-016 SHALL ignore we while init_busy=1; no user write takes effect.
REQ-017 SHALL load qdpo from mem[dpra] at the edge when qdpo_ce=1 and qdpo_srst=0, giving one-cycle read latency.
REQ-018 SHALL clear qdpo to 0 at the edge when qdpo_srst=1, regardless of qdpo_ce; srst has priority.
REQ-019 SHALL hold qdpo when qdpo_ce=0 and qdpo_srst=0.
REQ-020 SHALL, on a read and write to the same address in the same cycle, be write-first: qdpo gets enabled lanes from d and the remaining lanes from the old word.
REQ-021 SHALL run a clear-sequencer FSM with states INIT and READY; INIT writes 0 to address cnt and increments cnt each cycle.
REQ-022 SHALL move from INIT to READY on the cycle after writing DEPTH-1, deasserting init_busy in that same edge; the clear takes exactly DEPTH cycles.
REQ-023 SHALL wrap cnt modulo DEPTH without extra logic; reads during INIT return whatever the addressed word currently holds.

Reset
REQ-024 SHALL, while rst_n=0, force qdpo=0, init_busy=1, FSM=INIT, cnt=0 asynchronously; memory contents are not reset directly.
REQ-025 SHALL restart the full clear sequence if rst_n asserts mid-INIT or in READY.

Configuration
REQ-026 SHALL, when DIST_RAM_PARITY_EN is defined, store one even-parity bit per byte lane, add output port par_err (1 bit, reset 0), and register par_err alongside qdpo as OR of lane mismatches (cleared by qdpo_srst, held when qdpo_ce=0).
REQ-027 SHALL, without DIST_RAM_PARITY_EN, have no parity storage and no par_err port.

Structure
REQ-028 SHALL place the FSM state encoding (INIT, READY) and the default DW/DEPTH constants in package dist_ram_pkg.
REQ-029 SHALL contain one sub-module, dist_ram_byte_merge, combinationally merging old word, d, and be for writes and write-first forwarding.

Verification
REQ-030 SHALL test: reset release with DEPTH=64 -> init_busy high exactly 64 cycles, then every address reads 0.
REQ-031 SHALL test: write a=5, d=32'hA5A5_1234, be=4'hF; read dpra=5 with ce=1 -> qdpo=32'hA5A5_1234 one cycle later.
REQ-032 SHALL test: with mem[5]=32'hA5A5_1234, write a=5, d=32'h0000_00FF, be=4'b0001 while dpra=5 -> qdpo=32'hA5A5_12FF same edge, write-first.
REQ-033 SHALL test: qdpo_ce=1 and qdpo_srst=1 together -> qdpo=0; then ce=0, dpra changes -> qdpo holds.
REQ-034 SHALL test: we=1 to a=3, d=32'h1 during INIT -> mem[3]=0 after the clear; rst_n pulse mid-INIT -> a full 64-cycle clear restarts.
REQ-035 SHALL test, with DIST_RAM_PARITY_EN: a forced flip of a stored bit in lane 2 -> par_err=1 on the next enabled read of that word, 0 after qdpo_srst.
